// File: rtl/noc_arb_pkg.sv
// Shared types and defaults for the NoC output-port arbiter.
// Holds the arbiter state encoding, default geometry and the stats counter width.
package noc_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_FLIT_W  = 8;
  localparam int STAT_W      = 16;

endpackage

// File: rtl/noc_port_arbiter_rr_picker.sv
// rr_picker: first asserted request at or after rr_ptr, wrapping modulo NUM_REQ.
// Purely combinational, no backpressure; result is consumed by the arbiter FSM.
module rr_picker import noc_arb_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  logic [2*NUM_REQ-1:0] dbl_req;
  logic [2*NUM_REQ-1:0] masked;

  // The upper copy is never masked, so wrap-around falls out of a plain
  // lowest-set-bit search over the doubled vector.
  assign dbl_req = {req, req};
  assign masked  = dbl_req & ({(2*NUM_REQ){1'b1}} << rr_ptr);
  assign any_req = |req;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
      if (masked[i]) begin
        grant              = '0;
        grant[i % NUM_REQ] = 1'b1;
        grant_idx          = IDX_W'(i % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/noc_port_arbiter.sv
// Wormhole round-robin arbiter into one output FIFO: 1 idle cycle per packet, then 1 flit/cycle combinationally;
// fifo_full_flag stalls the locked channel. Define NOC_ARB_STATS_EN for per-channel saturating packet counters.
module noc_port_arbiter import noc_arb_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int FLIT_W  = DEF_FLIT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*FLIT_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       fifo_write_flag,
  output logic [FLIT_W-1:0]          fifo_in,
  input  logic                       fifo_full_flag,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
`ifdef NOC_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]  pkt_count
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] grant_vec;
  logic [NUM_REQ-1:0] pick_vec;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               xfer;
  logic               tail_xfer;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (pick_vec),
    .grant_idx (pick_idx),
    .any_req   (pick_any)
  );

  // grant_vec is the registered one-hot twin of grant_id, so ready needs no decode.
  assign req_ready       = (state == LOCKED && !fifo_full_flag) ? grant_vec : '0;
  assign xfer            = |(req_valid & req_ready);
  assign tail_xfer       = |(req_valid & req_last & req_ready);
  assign fifo_write_flag = xfer;
  assign fifo_in         = xfer ? req_data[int'(grant_id)*FLIT_W +: FLIT_W] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      grant_vec <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state     <= LOCKED;
            grant_id  <= pick_idx;
            grant_vec <= pick_vec;
            busy      <= 1'b1;
          end
        end
        LOCKED: begin
          if (tail_xfer) begin
            state  <= IDLE;
            busy   <= 1'b0;
            rr_ptr <= (grant_id == IDX_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef NOC_ARB_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
    logic [STAT_W-1:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        cnt <= '0;
      else if (tail_xfer && grant_vec[g] && cnt != '1)
        cnt <= cnt + 1'b1;
    end
    assign pkt_count[g*STAT_W +: STAT_W] = cnt;
  end
`endif

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Bench for noc_port_arbiter: queued per-channel packet stimulus, a spec-level
// arbitration model and a negedge scoreboard monitor that checks every cycle.
module tb_noc_port_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           fifo_write_flag;
  logic [W-1:0]   fifo_in;
  logic           fifo_full_flag;
  logic [1:0]     grant_id;
  logic           busy;
`ifdef NOC_ARB_STATS_EN
  logic [N*16-1:0] pkt_count;
`endif

  noc_port_arbiter #(.NUM_REQ(N), .FLIT_W(W)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_last        (req_last),
    .req_ready       (req_ready),
    .fifo_write_flag (fifo_write_flag),
    .fifo_in         (fifo_in),
    .fifo_full_flag  (fifo_full_flag),
    .grant_id        (grant_id),
    .busy            (busy)
`ifdef NOC_ARB_STATS_EN
    ,
    .pkt_count       (pkt_count)
`endif
  );

  always #5 clk = ~clk;

  // {last, data} per flit
  logic [8:0] src_q [N][$];
  logic [8:0] exp_q [N][$];
  int grant_log[$];
  int wr_log[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit gaps       = 1'b0;
  int full_pct   = 0;
  bit full_force = 1'b0;

  // Reference model state: which channel owns the port and where the search starts.
  bit m_locked = 1'b0;
  int m_owner  = 0;
  int m_ptr    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int c = 0; c < N; c++) s += exp_q[c].size();
    return s;
  endfunction

  function automatic int q_at(input int q[$], input int i);
    if (i < 0 || i >= q.size()) return -1;
    return q[i];
  endfunction

  task automatic push(input int ch, input logic [7:0] d, input bit last);
    src_q[ch].push_back({last, d});
    exp_q[ch].push_back({last, d});
  endtask

  task automatic drive_inputs();
    for (int c = 0; c < N; c++) begin
      if (src_q[c].size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
        req_valid[c]        = 1'b1;
        req_data[c*W +: W]  = src_q[c][0][7:0];
        req_last[c]         = src_q[c][0][8];
      end else begin
        req_valid[c]        = 1'b0;
        req_data[c*W +: W]  = 8'($urandom);
        req_last[c]         = 1'($urandom);
      end
    end
    fifo_full_flag = full_force || ($urandom_range(99) < full_pct);
  endtask

  task automatic assert_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    for (int c = 0; c < N; c++) begin
      src_q[c].delete();
      exp_q[c].delete();
    end
  endtask

  task automatic release_reset();
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((pending() != 0 || m_locked) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk({name, "_drain_in_budget"}, 64'(n < budget), 64'd1);
    @(negedge clk); #1;
  endtask

  // Driver: advance a channel's source queue only on a handshake seen before the edge.
  initial begin : driver
    logic [N-1:0] acc;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    fifo_full_flag = 1'b0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      for (int c = 0; c < N; c++)
        if (acc[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
      drive_inputs();
    end
  end

  // Monitor + model: expected outputs follow from inputs and the model's owner/pointer.
  initial begin : monitor
    bit prev_busy = 1'b0;
    logic [8:0] e;
    bit exp_wr;
    bit found;
    forever begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1 && !prev_busy) grant_log.push_back(int'(grant_id));
      prev_busy = (busy === 1'b1);
      if (fifo_write_flag === 1'b1) wr_log.push_back(cyc);
      if (reset) begin
        m_locked = 1'b0;
        m_owner  = 0;
        m_ptr    = 0;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_write", 64'(fifo_write_flag), 64'd0);
        chk("reset_grant_id", 64'(grant_id), 64'd0);
        continue;
      end
      exp_wr = m_locked && req_valid[m_owner] && !fifo_full_flag;
      chk("busy", 64'(busy), 64'(m_locked));
      chk("req_ready", 64'(req_ready), (m_locked && !fifo_full_flag) ? 64'(1) << m_owner : 64'd0);
      chk("fifo_write_flag", 64'(fifo_write_flag), 64'(exp_wr));
      if (m_locked) chk("grant_id", 64'(grant_id), 64'(m_owner));
      if (exp_wr) begin
        if (exp_q[m_owner].size() == 0) begin
          chk("scoreboard_underflow", 64'(exp_q[m_owner].size()), 64'd1);
        end else begin
          e = exp_q[m_owner].pop_front();
          chk("fifo_in", 64'(fifo_in), 64'(e[7:0]));
          if (e[8]) begin
            m_locked = 1'b0;
            m_ptr    = (m_owner + 1) % N;
          end
        end
      end else begin
        chk("fifo_in_idle", 64'(fifo_in), 64'd0);
        if (!m_locked) begin
          found = 1'b0;
          for (int k = 0; k < N; k++) begin
            if (!found && req_valid[(m_ptr + k) % N]) begin
              found    = 1'b1;
              m_owner  = (m_ptr + k) % N;
              m_locked = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #(900_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    int g0, w0, t0, n;
    int len;
    int ch;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_rr_ptr", 64'(dut.rr_ptr), 64'd0);
    release_reset();

    // Single requester, 3-flit packet on ch1.
    @(negedge clk); #1;
    g0 = grant_log.size(); w0 = wr_log.size(); t0 = cyc;
    push(1, 8'h11, 1'b0); push(1, 8'h22, 1'b0); push(1, 8'h33, 1'b1);
    wait_drain("single", 100);
    chk("single_grant", 64'(q_at(grant_log, g0)), 64'd1);
    chk("single_first_write_cycle", 64'(q_at(wr_log, w0) - t0), 64'd2);
    chk("single_consec_1", 64'(q_at(wr_log, w0+1) - q_at(wr_log, w0)), 64'd1);
    chk("single_consec_2", 64'(q_at(wr_log, w0+2) - q_at(wr_log, w0+1)), 64'd1);
    chk("single_busy_after", 64'(busy), 64'd0);
    chk("single_rr_ptr", 64'(dut.rr_ptr), 64'd2);

    // Round robin: every channel holds 1-flit packets continuously from reset.
    assert_reset();
    @(negedge clk); #1;
    for (int j = 0; j < 2; j++)
      for (int c = 0; c < N; c++) push(c, 8'(8'h40 + c*16 + j), 1'b1);
    g0 = grant_log.size(); w0 = wr_log.size();
    release_reset();
    wait_drain("rr", 200);
    for (int i = 0; i < 2*N; i++)
      chk($sformatf("rr_order_%0d", i), 64'(q_at(grant_log, g0+i)), 64'(i % N));
    for (int i = 1; i < 2*N; i++)
      chk($sformatf("rr_spacing_%0d", i), 64'(q_at(wr_log, w0+i) - q_at(wr_log, w0+i-1)), 64'd2);

    // Wormhole lock: ch0 4 flits, ch2 requests a cycle later.
    g0 = grant_log.size(); w0 = wr_log.size();
    for (int i = 0; i < 4; i++) push(0, 8'(8'hA0 + i), i == 3);
    @(negedge clk); #1;
    push(2, 8'hC0, 1'b1);
    wait_drain("lock", 100);
    chk("lock_first", 64'(q_at(grant_log, g0)), 64'd0);
    chk("lock_second", 64'(q_at(grant_log, g0+1)), 64'd2);
    chk("lock_handover", 64'(q_at(wr_log, w0+4) - q_at(wr_log, w0+3)), 64'd2);

    // Backpressure: 3 full cycles in the middle of a ch3 packet.
    w0 = wr_log.size();
    for (int i = 0; i < 6; i++) push(3, 8'(8'h30 + i), i == 5);
    n = 0;
    while (exp_q[3].size() > 4 && n < 100) begin @(negedge clk); #1; n++; end
    chk("bp_reached_mid", 64'(n < 100), 64'd1);
    full_force = 1'b1;
    repeat (3) @(negedge clk);
    #1 full_force = 1'b0;
    wait_drain("bp", 100);
    chk("bp_write_count", 64'(wr_log.size() - w0), 64'd6);

    // Move rr_ptr to 3, then reset in the middle of a 5-flit ch1 packet.
    push(2, 8'h5A, 1'b1);
    wait_drain("pre_reset", 100);
    chk("pre_reset_rr_ptr", 64'(dut.rr_ptr), 64'd3);
    for (int i = 0; i < 5; i++) push(1, 8'(8'h71 + i), i == 4);
    n = 0;
    while (exp_q[1].size() > 3 && n < 100) begin @(negedge clk); #1; n++; end
    chk("midpkt_reached", 64'(n < 100), 64'd1);
    assert_reset();
    @(negedge clk); #1;
    chk("midpkt_busy", 64'(busy), 64'd0);
    chk("midpkt_ready", 64'(req_ready), 64'd0);
    chk("midpkt_write", 64'(fifo_write_flag), 64'd0);
    g0 = grant_log.size();
    push(3, 8'h63, 1'b1);
    push(2, 8'h62, 1'b1);
    release_reset();
    wait_drain("post_reset", 100);
    chk("post_reset_first", 64'(q_at(grant_log, g0)), 64'd2);
    chk("post_reset_second", 64'(q_at(grant_log, g0+1)), 64'd3);

    // Randomised traffic with valid gaps and random FIFO full.
    gaps = 1'b1;
    full_pct = 25;
    for (int p = 0; p < 80; p++) begin
      ch  = $urandom_range(N-1);
      len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) push(ch, 8'($urandom), i == len-1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      #1;
    end
    wait_drain("random", 20000);
    gaps = 1'b0;
    full_pct = 0;

`ifdef NOC_ARB_STATS_EN
    assert_reset();
    release_reset();
    @(negedge clk); #1;
    for (int p = 0; p < 5; p++) begin
      push(1, 8'(8'h90 + p), 1'b0);
      push(1, 8'(8'hB0 + p), 1'b1);
    end
    wait_drain("stats", 200);
    for (int c = 0; c < N; c++)
      chk($sformatf("pkt_count_%0d", c), 64'(pkt_count[c*16 +: 16]), (c == 1) ? 64'd5 : 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_port_arbiter.md
# noc_port_arbiter

- Wormhole round-robin arbiter that shares one 8-bit output-port FIFO among NUM_REQ input channels of a NoC router.
- Grants one requester at a time and holds the grant for a whole packet, up to and including its tail flit.
- Drives the FIFO's write interface directly from the granted channel, with backpressure from the FIFO full flag.
- Sits between the router's input buffers/route-compute stage and each output-port FIFO.

## Interface
Parameters:
- NUM_REQ, 4, number of requesting input channels (2..8)
- FLIT_W, 8, flit width in bits; matches the output FIFO data width

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- req_valid  input  NUM_REQ  per-channel flit valid
- req_data  input  NUM_REQ*FLIT_W  per-channel flit; channel i occupies bits [i*FLIT_W +: FLIT_W]
- req_last  input  NUM_REQ  per-channel tail-flit marker, qualified by req_valid
- req_ready  output  NUM_REQ  per-channel accept; a flit transfers when valid && ready
- fifo_write_flag  output  1  write strobe to the output FIFO
- fifo_in  output  FLIT_W  flit to the output FIFO
- fifo_full_flag  input  1  output FIFO full
- grant_id  output  $clog2(NUM_REQ)  currently granted channel; only meaningful while busy
- busy  output  1  a packet is currently locked

## Operation
State machine with two states, IDLE and LOCKED.

IDLE:
- All req_ready are 0 and fifo_write_flag is 0.
- If any req_valid is high, pick the first asserted channel starting at rr_ptr and wrapping modulo NUM_REQ.
- Register that channel into grant_id and go to LOCKED.
- If no request is pending, stay in IDLE.

LOCKED:
- req_ready[grant_id] = !fifo_full_flag; all other req_ready are 0.
- fifo_write_flag = req_valid[grant_id] && !fifo_full_flag.
- fifo_in = req_data[grant_id] (combinational mux; don't-care when no write).
- On a transfer with req_last[grant_id] = 1:
  - go to IDLE;
  - rr_ptr <= grant_id + 1, wrapping to 0 at NUM_REQ.
- Non-granted channels are never accepted and must hold their flits.
- A valid drop mid-packet on the granted channel leaves the lock held: no timeout, and no other channel is served.

Boundary cases:
- fifo_full_flag high in LOCKED: no write and no ready; state and grant hold.
- Single-flit packet (valid and last on the first flit): one LOCKED cycle, then back to IDLE.
- rr_ptr at NUM_REQ-1 with a grant to NUM_REQ-1: rr_ptr wraps to 0.
- All channels requesting continuously: service order is strictly rotating, so no starvation.
- Reset asserted mid-packet: immediate return to IDLE, and the partial packet is abandoned. The FIFO is reset by the same signal.

## Timing
Reset values:
- state IDLE, rr_ptr 0, grant_id 0, busy 0
- req_ready all 0, fifo_write_flag 0, fifo_in 0 when not writing

Latency and throughput:
- Arbitration takes 1 cycle: a request seen in IDLE at edge N is granted, and its first flit can transfer in cycle N+1.
- In LOCKED, throughput is one flit per cycle and the flit reaches the FIFO in the same cycle (combinational path).
- Each packet costs one IDLE bubble cycle before it; back-to-back packets therefore take len+1 cycles each.

Outputs:
- busy = (state == LOCKED), registered.
- grant_id is registered.
- req_ready and fifo_write_flag are combinational from the registered state and fifo_full_flag.

## Configuration
- Macro: NOC_ARB_STATS_EN.
- Defined:
  - adds output port pkt_count (NUM_REQ*16 bits), one counter per channel;
  - a channel's counter increments on each accepted tail flit and saturates at 16'hFFFF;
  - counters reset to 0.
- Undefined: the port and the counters are absent; arbitration behaviour is identical in both builds.

## Structure
Shared package noc_arb_pkg:
- state enum arb_state_t {IDLE, LOCKED}
- localparam defaults DEF_NUM_REQ = 4 and DEF_FLIT_W = 8
- stats counter width STAT_W = 16

Sub-module rr_picker:
- Combinational.
- Inputs: req vector and rr_ptr.
- Outputs: one-hot grant and encoded index, using a double-width mask-and-priority method.
- noc_port_arbiter holds the FSM, pointer, datapath mux and optional counters.

## Test plan
- Single requester: ch1 sends a 3-flit packet 0x11, 0x22, 0x33 (last on 0x33).
  - Expect one IDLE cycle, then three consecutive fifo_write_flag cycles with those values.
  - Expect grant_id = 1 during the packet, then busy = 0 and rr_ptr = 2.
- Round robin: all four channels hold 1-flit packets continuously from reset.
  - Expect grant order 0, 1, 2, 3, 0, with each packet taking 2 cycles.
- Wormhole lock: ch0 sends a 4-flit packet while ch2 requests from cycle 1.
  - Expect req_ready[2] = 0 until ch0's tail transfers; ch2 is granted on the next IDLE cycle.
- Backpressure: fifo_full_flag held high for 3 cycles in the middle of ch3's packet.
  - Expect no writes and req_ready[3] = 0 during those cycles, and no flit lost or duplicated.
  - Expect the output sequence to match the input sequence.
- Reset mid-packet: assert reset after the 2nd of 5 flits.
  - Expect busy, req_ready and fifo_write_flag to be 0 immediately.
  - After release with ch2 requesting, expect ch2 to be granted first (rr_ptr = 0 search).
- With NOC_ARB_STATS_EN: feed ch1 five packets.
  - Expect pkt_count[ch1] = 5 and all other counters 0.
  - With a counter preloaded to 0xFFFF via the bench, expect it to stay at 0xFFFF.
